// File: rtl/bcd_countdown_timer.sv
// BCD minutes:seconds countdown timer with keypad entry, a clock-cycle prescaler
// for the one-second tick, and IDLE/RUN/PAUSE control.
module bcd_countdown_timer #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 100
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    key_valid,
  input  logic [3:0]              key,
  input  logic                    start,
  input  logic                    stop,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    running,
  output logic                    done
);

  localparam int NUM_DIGITS = MIN_DIGITS + 2;
  localparam int CW         = 4 * NUM_DIGITS;
  localparam int PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d, count_dec;
  logic [PW-1:0]   psc_q, psc_d;
  logic            done_q, done_d;
  logic            tick;
  logic            key_ok;

  // Digit 0 is seconds units, digit 1 seconds tens (borrows from 0 to 5),
  // every minute digit borrows from 0 to 9.
  function automatic logic [CW-1:0] dec_count(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    logic          borrow;
    r      = c;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (c[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = c[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick      = (psc_q == PSC_LAST);
  assign key_ok    = key_valid && (key <= 4'd9);
  assign count_dec = dec_count(count_q);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    psc_d   = psc_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stop) begin
          count_d = '0;
        end else if (key_ok) begin
          count_d = {count_q[CW-5:0], key};
        end else if (start && !zero) begin
          state_d = RUN;
          psc_d   = '0;
        end
      end
      RUN: begin
        if (tick) begin
          count_d = count_dec;
          psc_d   = '0;
          // Expiry beats a coincident pause request.
          if (count_dec == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (stop) begin
            state_d = PAUSE;
          end
        end else if (stop) begin
          state_d = PAUSE;
        end else begin
          psc_d = psc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          count_d = '0;
          psc_d   = '0;
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      count_q <= '0;
      psc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      done_q  <= done_d;
    end
  end

  assign sec_ones = count_q[3:0];
  assign sec_tens = count_q[7:4];
  assign mins     = count_q[CW-1:8];
  assign zero     = (count_q == '0);
  assign running  = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: an arithmetic minutes/seconds model is
// compared every cycle, plus literal expectations at key points.
module tb_bcd_countdown_timer;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] sec_ones, sec_tens;
  logic [7:0] mins;
  logic       zero, running, done;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  bcd_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(TICK)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key(key),
    .start(start), .stop(stop), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .mins(mins), .zero(zero), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: count held as plain minutes (0..99) and seconds value (0..99).
  int m_min = 0, m_sec = 0, m_psc = 0, m_mode = 0;  // mode 0 idle, 1 run, 2 pause
  bit m_done = 1'b0;

  always @(posedge clk) begin
    int nmin, nsec, npsc, nmode, v;
    bit ndone;
    nmin = m_min; nsec = m_sec; npsc = m_psc; nmode = m_mode; ndone = 1'b0;
    if (clr) begin
      nmin = 0; nsec = 0; npsc = 0; nmode = 0;
    end else if (m_mode == 0) begin
      if (stop) begin
        nmin = 0; nsec = 0;
      end else if (key_valid && key < 10) begin
        v = ((m_min * 100 + m_sec) * 10 + int'(key)) % 10000;
        nmin = v / 100; nsec = v % 100;
      end else if (start && (m_min + m_sec) != 0) begin
        nmode = 1; npsc = 0;
      end
    end else if (m_mode == 1) begin
      if (m_psc == TICK - 1) begin
        npsc = 0;
        if (m_sec == 0) begin nmin = m_min - 1; nsec = 59; end
        else nsec = m_sec - 1;
        if (nmin == 0 && nsec == 0) begin ndone = 1'b1; nmode = 0; end
        else if (stop) nmode = 2;
      end else if (stop) begin
        nmode = 2;
      end else begin
        npsc = m_psc + 1;
      end
    end else begin
      if (stop) begin nmin = 0; nsec = 0; npsc = 0; nmode = 0; end
      else if (start) nmode = 1;
    end
    m_min <= nmin; m_sec <= nsec; m_psc <= npsc; m_mode <= nmode; m_done <= ndone;
  end

  always @(negedge clk) begin
    logic [18:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {m_mode == 1, m_done, (m_min == 0 && m_sec == 0),
               4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
      act_v = {running, done, zero, mins, sec_tens, sec_ones};
      check("cycle_model", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key = k; step(1); key_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic expect_cnt(input string name, input logic [15:0] exp);
    check(name, {16'd0, mins, sec_tens, sec_ones}, {16'd0, exp});
  endtask

  initial begin
    step(2);
    chk_en = 1'b1;
    clr = 1'b0;
    expect_cnt("reset_count", 16'h0000);
    check("reset_flags", {zero, running, done}, 3'b100);

    // Entry and first tick: 01:30 -> 01:29 after TICK cycles.
    press(4'd1); press(4'd3); press(4'd0);
    expect_cnt("entry_130", 16'h0130);
    go();
    step(TICK);
    expect_cnt("first_tick", 16'h0129);
    check("running_after_tick", running, 1'b1);

    // Borrow across seconds and minutes.
    do_clr();
    press(4'd1); press(4'd0); press(4'd0);
    go(); step(TICK);
    expect_cnt("borrow_0100", 16'h0059);
    do_clr();
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    go(); step(TICK);
    expect_cnt("borrow_1000", 16'h0959);

    // Expiry from 00:05.
    do_clr();
    press(4'd5); go(); step(5 * TICK);
    expect_cnt("expired", 16'h0000);
    check("expiry_flags", {done, zero, running}, 3'b110);
    step(1);
    check("done_one_cycle", done, 1'b0);

    // Pause mid-run with prescaler held at 2, then resume.
    do_clr();
    press(4'd1); press(4'd0); go();
    step(6);
    stop = 1'b1; step(1); stop = 1'b0;
    expect_cnt("paused", 16'h0009);
    check("paused_not_running", running, 1'b0);
    press(4'd7);
    step(20);
    expect_cnt("pause_frozen", 16'h0009);
    go();
    check("resumed", running, 1'b1);
    step(1);
    expect_cnt("resume_no_tick", 16'h0009);
    step(1);
    expect_cnt("resume_tick", 16'h0008);

    // Full entry, illegal key, stop clears.
    do_clr();
    repeat (5) press(4'd9);
    expect_cnt("entry_9999", 16'h9999);
    press(4'hA);
    expect_cnt("illegal_key", 16'h9999);
    stop = 1'b1; step(1); stop = 1'b0;
    expect_cnt("idle_stop_clear", 16'h0000);

    // clr mid-run, then start with zero count is ignored.
    press(4'd2); go(); step(2);
    do_clr();
    expect_cnt("clr_in_run", 16'h0000);
    check("clr_flags", {running, done, zero}, 3'b001);
    go();
    check("start_on_zero", {running, zero}, 2'b01);

    // Key with start: key wins. Start with stop: stop wins.
    key_valid = 1'b1; key = 4'd3; start = 1'b1; step(1);
    key_valid = 1'b0; start = 1'b0;
    expect_cnt("key_beats_start", 16'h0003);
    check("key_beats_start_idle", running, 1'b0);
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    expect_cnt("stop_beats_start", 16'h0000);

    // Tick coinciding with stop: decrement applied, then pause.
    press(4'd2); go(); step(TICK - 1);
    stop = 1'b1; step(1); stop = 1'b0;
    expect_cnt("tick_with_stop", 16'h0001);
    check("tick_with_stop_paused", running, 1'b0);
    // Resume; the next tick expires, coinciding with stop: expiry wins.
    go(); step(TICK - 1);
    stop = 1'b1; step(1); stop = 1'b0;
    check("expiry_beats_pause", {done, running, zero}, 3'b101);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
